// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns pc, IR, flags and the retired counter.
// Latency 3 cycles per instruction plus one per imem_ack wait cycle; fetch waits indefinitely for ack.
module instr_sequencer #(
    parameter int PC_W  = 8,
    parameter int LIT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [6+LIT_W:0]   imem_rdata,
    output logic [6:0]         opcode,
    output logic [LIT_W-1:0]   literal,
    output logic               exec_en,
    input  logic               is_jump,
    input  logic [3:0]         jump_cond,
    input  logic               flags_write,
    input  logic [3:0]         alu_flags,
    output logic [3:0]         flags,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               busy,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [6:0] HALT_OP = 7'h7F;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

    state_t              state;
    logic [6+LIT_W:0]    ir;
    logic [PC_W-1:0]     jump_target;
    logic                cond_ok;

    assign opcode    = ir[6+LIT_W:LIT_W];
    assign literal   = ir[LIT_W-1:0];
    assign imem_addr = pc;

    generate
        if (PC_W > LIT_W) begin : g_ext
            assign jump_target = {{(PC_W-LIT_W){1'b0}}, literal};
        end else begin : g_trunc
            assign jump_target = literal[PC_W-1:0];
        end
    endgenerate

    // Conditions see the flags register as it was before this EXEC's write.
    always_comb begin
        cond_ok = 1'b0;
        case (jump_cond)
            4'b1111: cond_ok = 1'b1;
            4'b0001: cond_ok = flags[3];
            4'b0010: cond_ok = !flags[3];
            4'b0011: cond_ok = !flags[3] && !flags[2];
            4'b0100: cond_ok = flags[2];
            4'b0101: cond_ok = !flags[2];
            4'b0110: cond_ok = flags[3] || flags[2];
            4'b0111: cond_ok = flags[1];
            4'b1000: cond_ok = flags[0];
            default: cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            flags    <= '0;
            retired  <= '0;
            imem_req <= 1'b0;
            exec_en  <= 1'b0;
            halted   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            exec_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    state   <= EXEC;
                    exec_en <= 1'b1;
                end
                EXEC: begin
                    if (flags_write) begin
                        flags <= alu_flags;
                    end
                    if (retired != {CNT_W{1'b1}}) begin
                        retired <= retired + 1'b1;
                    end
                    if (opcode == HALT_OP) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        if (is_jump && cond_ok) begin
                            pc <= jump_target;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                HALT: begin
                    if (run) begin
                        pc       <= '0;
                        flags    <= '0;
                        halted   <= 1'b0;
                        busy     <= 1'b1;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction memory with per-address ack delay, a small control-unit
// decoder, and an instruction-level interpreter whose per-EXEC expectations feed a scoreboard.
module tb_instr_sequencer;

    localparam int PC_W  = 8;
    localparam int LIT_W = 8;
    localparam int CNT_W = 5;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [14:0]       imem_rdata;
    logic [6:0]        opcode;
    logic [LIT_W-1:0]  literal;
    logic              exec_en;
    logic              is_jump;
    logic [3:0]        jump_cond;
    logic              flags_write;
    logic [3:0]        alu_flags;
    logic [3:0]        flags;
    logic [PC_W-1:0]   pc;
    logic              halted;
    logic              busy;
    logic [CNT_W-1:0]  retired;

    instr_sequencer #(.PC_W(PC_W), .LIT_W(LIT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .opcode(opcode), .literal(literal), .exec_en(exec_en),
        .is_jump(is_jump), .jump_cond(jump_cond), .flags_write(flags_write), .alu_flags(alu_flags),
        .flags(flags), .pc(pc), .halted(halted), .busy(busy), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] mem [256];
    logic [3:0]  afl [256];
    int          dly [256];

    // Control unit: op[6:5]=11 jump (cond op[3:0]), op[4] writes flags; 7F is HALT.
    function automatic logic [5:0] cu(input logic [6:0] op);
        logic j, fw;
        j  = (op[6:5] == 2'b11) && (op != 7'h7F);
        fw = op[4] && (op != 7'h7F);
        return {j, op[3:0], fw};
    endfunction

    assign {is_jump, jump_cond, flags_write} = cu(opcode);
    assign alu_flags = afl[imem_addr];

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit z, n;
        z = f[3];
        n = f[2];
        case (c)
            4'b1111: return 1'b1;
            4'b0001: return z;
            4'b0010: return !z;
            4'b0011: return !z && !n;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return z || n;
            4'b0111: return f[1];
            4'b1000: return f[0];
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic [7:0] pc;
        logic [6:0] op;
        logic [7:0] lit;
        logic [3:0] fl;
        logic [4:0] ret;
        int         reqc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_pc;
    logic [3:0] m_flags;
    logic [4:0] m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Instruction-level interpreter: one expectation per executed instruction.
    task automatic model_run(input int steps);
        logic [14:0] ins;
        logic [6:0]  op;
        logic [7:0]  lit;
        logic [5:0]  c;
        exp_t        e;
        for (int i = 0; i < steps; i++) begin
            ins = mem[m_pc];
            op  = ins[14:8];
            lit = ins[7:0];
            c   = cu(op);
            e.pc = m_pc; e.op = op; e.lit = lit; e.fl = m_flags; e.ret = m_ret;
            e.reqc = dly[m_pc] + 1;
            sb_q.push_back(e);
            if (m_ret != '1) m_ret++;
            if (op == 7'h7F) break;
            if (c[5] && cond_true(c[4:1], m_flags)) m_pc = lit;
            else m_pc = m_pc + 8'd1;
            if (c[0]) m_flags = afl[e.pc];
        end
    endtask

    // Memory responder: ack after dly[addr] wait cycles; random stray acks when not fetching.
    bit in_fetch = 1'b0;
    int wcnt = 0;
    always @(negedge clk) begin
        if (imem_req) begin
            if (!in_fetch) begin
                in_fetch = 1'b1;
                wcnt = dly[imem_addr];
            end
            if (wcnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 15'($urandom);
                wcnt--;
            end
        end else begin
            in_fetch   = 1'b0;
            imem_ack   = 1'($urandom);
            imem_rdata = 15'($urandom);
        end
    end

    // Monitor: every exec strobe consumes one expectation.
    int   reqc = 0;
    exp_t em;
    always @(negedge clk) begin
        if (!rst_n) begin
            reqc = 0;
        end else begin
            if (imem_req) reqc++;
            if (exec_en) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_exec: got exec at pc %0h want none", pc);
                end else begin
                    em = sb_q.pop_front();
                    chk("exec_pc", 32'(pc), 32'(em.pc));
                    chk("exec_opcode", 32'(opcode), 32'(em.op));
                    chk("exec_literal", 32'(literal), 32'(em.lit));
                    chk("exec_flags", 32'(flags), 32'(em.fl));
                    chk("exec_retired", 32'(retired), 32'(em.ret));
                    chk("exec_req_cycles", 32'(reqc), 32'(em.reqc));
                end
                reqc = 0;
            end
        end
    end

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) begin
            mem[a] = 15'h0000;
            afl[a] = 4'h0;
            dly[a] = 0;
        end
    endtask

    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Returns at the rising edge just after the last expected EXEC.
    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic reset_in_fetch();
        #1;
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        chk("pre_rst_retired", 32'(retired), 32'(m_ret));
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_literal", 32'(literal), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        m_pc = 8'd0;
        m_flags = 4'd0;
        m_ret = 5'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("idle_req", 32'(imem_req), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        m_pc = 8'd0;
        m_flags = 4'd0;
        m_ret = 5'd0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("reset_req", 32'(imem_req), 32'd0);
        chk("reset_exec_en", 32'(exec_en), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_opcode", 32'(opcode), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        rst_n = 1'b1;

        // Directed program: MOV/NOP, delayed fetch, JEQ taken/not taken, same-cycle flag write, jumps via 0xFF.
        mem[8'h00] = {7'b0000010, 8'h05};
        mem[8'h01] = {7'b0000000, 8'h00};
        mem[8'h02] = {7'b0010000, 8'h00};  afl[8'h02] = 4'b1000;
        mem[8'h03] = {7'b1100001, 8'h20};  dly[8'h03] = 4;
        mem[8'h20] = {7'b0010000, 8'h00};  afl[8'h20] = 4'b0000;
        mem[8'h21] = {7'b1100001, 8'h40};
        mem[8'h22] = {7'b1110001, 8'h50};  afl[8'h22] = 4'b1000;
        mem[8'h23] = {7'b1101111, 8'hFF};
        mem[8'hFF] = {7'b1101111, 8'h10};
        mem[8'h10] = {7'b1101111, 8'h00};
        model_run(16);
        pulse_run();
        wait_drain(1000, "directed");
        reset_in_fetch();

        // Random program; 200 instructions also drive the counter into saturation.
        for (int a = 0; a < 256; a++) begin
            mem[a] = {7'($urandom_range(0, 126)), 8'($urandom)};
            afl[a] = 4'($urandom);
            dly[a] = $urandom_range(0, 3);
        end
        model_run(200);
        pulse_run();
        wait_drain(5000, "random");
        reset_in_fetch();

        // Wrap at 0xFF, HALT at 7, then restart from HALT with flags cleared.
        clear_mem();
        mem[8'h00] = {7'b1100010, 8'hFF};
        mem[8'hFF] = {7'b0010000, 8'h00};  afl[8'hFF] = 4'b1000;
        mem[8'h07] = {7'b1111111, 8'h00};
        dly[8'h05] = 2;
        model_run(50);
        pulse_run();
        wait_drain(1000, "halt1");
        repeat (5) begin
            @(negedge clk);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_pc", 32'(pc), 32'd7);
            chk("halt_busy", 32'(busy), 32'd0);
        end
        chk("halt_flags", 32'(flags), 32'(m_flags));
        chk("halt_retired", 32'(retired), 32'(m_ret));
        m_pc = 8'd0;
        m_flags = 4'd0;
        model_run(50);
        pulse_run();
        wait_drain(1000, "halt2");
        @(negedge clk);
        chk("rehalt_halted", 32'(halted), 32'd1);
        chk("rehalt_pc", 32'(pc), 32'd7);
        chk("rehalt_retired", 32'(retired), 32'(m_ret));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
